// File: rtl/game_pkg.sv
// Shared types and constants for the lane-defence game engine.
// Renderer tables map (dir, step) to screen coordinates.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [7:0] coord_t;
  localparam int TAB_STEPS = 3;

  // Outer index is dir (right..up), inner is step (2..0).
  localparam coord_t [3:0][TAB_STEPS-1:0] X_TAB = '{
    '{8'd110, 8'd130, 8'd150},
    '{8'd50,  8'd30,  8'd10},
    '{8'd80,  8'd80,  8'd80},
    '{8'd80,  8'd80,  8'd80}
  };

  localparam coord_t [3:0][TAB_STEPS-1:0] Y_TAB = '{
    '{8'd60,  8'd60,  8'd60},
    '{8'd60,  8'd60,  8'd60},
    '{8'd80,  8'd95,  8'd110},
    '{8'd40,  8'd25,  8'd10}
  };

endpackage

// File: rtl/monster_wave_engine_if.sv
// Control inputs and game-state outputs of the wave engine.
// master drives the buttons/ticks, slave is the engine.
interface monster_wave_engine_if #(
  parameter int MONSTERS = 12,
  parameter int STEPS    = 3,
  parameter int LIVES    = 3,
  parameter int SCORE_W  = 16
);
  localparam int STEP_W  = $clog2(STEPS);
  localparam int LIVES_W = $clog2(LIVES + 1);

  logic                       start;
  logic                       move_tick;
  logic                       attack_req;
  logic [1:0]                 hero_dir;
  logic                       playing;
  logic                       game_over;
  logic [LIVES_W-1:0]         lives;
  logic [SCORE_W-1:0]         score;
  logic [MONSTERS-1:0]        mon_valid;
  logic [2*MONSTERS-1:0]      mon_dir;
  logic [STEP_W*MONSTERS-1:0] mon_step;
  logic [MONSTERS-1:0]        kill_pulse;

  modport master (
    output start, move_tick, attack_req, hero_dir,
    input  playing, game_over, lives, score,
    input  mon_valid, mon_dir, mon_step, kill_pulse
  );

  modport slave (
    input  start, move_tick, attack_req, hero_dir,
    output playing, game_over, lives, score,
    output mon_valid, mon_dir, mon_step, kill_pulse
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR, free running.
// Drives spawn decisions for the wave engine.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_game,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]}
             ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/monster_wave_engine.sv
// Lane-defence game state: spawns, moves and kills monsters,
// and keeps lives, score and the game phase.
module monster_wave_engine
  import game_pkg::*;
#(
  parameter int          MONSTERS      = 12,
  parameter int          STEPS         = 3,
  parameter int          ATTACK_WINDOW = 500,
  parameter int          LIVES         = 3,
  parameter int          SCORE_W       = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk_game,
  input  logic                rst_n,
  monster_wave_engine_if.slave bus
);

  localparam int STEP_W  = $clog2(STEPS);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int CNT_W   = $clog2(ATTACK_WINDOW + 1);
  localparam int CNT_N   = $clog2(MONSTERS + 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  state_e               state;
  logic                 playing_q;
  logic                 over_q;
  logic [LIVES_W-1:0]   lives_q;
  logic [SCORE_W-1:0]   score_q;
  logic [MONSTERS-1:0]  kp_q;
  logic                 start_q;
  logic                 move_q;
  logic                 atk_q;
  logic                 start_e;
  logic                 move_e;
  logic                 atk_e;
  logic [CNT_W-1:0]     win_cnt;
  dir_e                 atk_dir;
  logic [15:0]          lfsr;
  logic                 unused_lfsr;
  logic                 run;
  logic                 win_act;
  logic                 spawn_en;
  logic [MONSTERS-1:0]  valid;
  logic [MONSTERS-1:0]  kill;
  logic [MONSTERS-1:0]  arrive;
  logic [MONSTERS-1:0]  free;
  logic [MONSTERS-1:0]  spawn_oh;
  logic [CNT_N-1:0]     kill_n;
  logic [CNT_N-1:0]     arr_n;
  int                   lives_left;
  logic [SCORE_W:0]     score_sum;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_game (clk_game),
    .rst_n    (rst_n),
    .state    (lfsr)
  );

  assign start_e  = bus.start & ~start_q;
  assign move_e   = bus.move_tick & ~move_q;
  assign atk_e    = bus.attack_req & ~atk_q;
  // run is low on the cycle that lives hit 0: that cycle flushes to OVER
  assign run      = (state == PLAY) && (lives_q != '0);
  assign win_act  = (win_cnt != '0);
  assign spawn_en = run && move_e && (lfsr[1:0] != 2'b00);
  assign free     = ~valid;
  assign spawn_oh = spawn_en ? (free & (~free + MONSTERS'(1))) : '0;

  assign kill_n      = CNT_N'($countones(kill));
  assign arr_n       = CNT_N'($countones(arrive));
  assign lives_left  = int'(lives_q) - int'(arr_n);
  assign score_sum   = {1'b0, score_q} + (SCORE_W + 1)'(kill_n);
  assign unused_lfsr = ^lfsr[15:4];

  for (genvar i = 0; i < MONSTERS; i++) begin : g_slot
    logic              v_q;
    logic [1:0]        d_q;
    logic [STEP_W-1:0] s_q;
    logic              at_end;

    assign at_end    = v_q && (s_q == LAST);
    assign kill[i]   = run && win_act && at_end
                     && (d_q == atk_dir);
    assign arrive[i] = run && move_e && at_end && !kill[i];
    assign valid[i]  = v_q;

    always_ff @(posedge clk_game or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        s_q <= '0;
      end else if (!run || kill[i] || arrive[i]) begin
        v_q <= 1'b0;
        d_q <= '0;
        s_q <= '0;
      end else if (spawn_oh[i]) begin
        v_q <= 1'b1;
        d_q <= lfsr[3:2];
        s_q <= '0;
      end else if (move_e && v_q) begin
        s_q <= s_q + STEP_W'(1);
      end
    end

    assign bus.mon_dir[2*i +: 2]           = d_q;
    assign bus.mon_step[STEP_W*i +: STEP_W] = s_q;
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
      lives_q   <= '0;
      score_q   <= '0;
      kp_q      <= '0;
      start_q   <= 1'b0;
      move_q    <= 1'b0;
      atk_q     <= 1'b0;
      win_cnt   <= '0;
      atk_dir   <= DIR_UP;
    end else begin
      start_q <= bus.start;
      move_q  <= bus.move_tick;
      atk_q   <= bus.attack_req;
      kp_q    <= kill;
      unique case (state)
        IDLE, OVER: begin
          if (start_e) begin
            state     <= PLAY;
            playing_q <= 1'b1;
            over_q    <= 1'b0;
            lives_q   <= LIVES_W'(LIVES);
            score_q   <= '0;
          end
        end
        PLAY: begin
          if (!run) begin
            state     <= OVER;
            playing_q <= 1'b0;
            over_q    <= 1'b1;
            win_cnt   <= '0;
          end else begin
            lives_q <= (lives_left <= 0) ? '0
                     : LIVES_W'(lives_left);
            score_q <= score_sum[SCORE_W] ? '1
                     : score_sum[SCORE_W-1:0];
            if (atk_e) begin
              atk_dir <= dir_e'(bus.hero_dir);
              win_cnt <= CNT_W'(ATTACK_WINDOW);
            end else if (win_act) begin
              win_cnt <= win_cnt - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.playing    = playing_q;
  assign bus.game_over  = over_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.mon_valid  = valid;
  assign bus.kill_pulse = kp_q;

endmodule

// File: doc/monster_wave_engine.md
# monster_wave_engine

Parametrised game-state engine for the lane-defence game. It spawns up to MONSTERS monsters on four approach lanes, advances them one step per move tick, resolves hero attacks against monsters at the final step, and tracks lives, score and the game phase. Inputs come from the button/direction decoder and the move-clock divider. Outputs feed the renderer, which maps (dir, step) to screen coordinates, and the score display.

## Interface
- MONSTERS, 12: number of monster slots.
- STEPS, 3: positions per lane; step STEPS-1 is adjacent to the hero.
- ATTACK_WINDOW, 500: cycles an attack remains active.
- LIVES, 3: lives at game start.
- SCORE_W, 16: score width.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- clk_game  in  1  game clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level; a rising edge starts a game from IDLE or OVER.
- move_tick  in  1  level from the divider; a rising edge is one move step.
- attack_req  in  1  level; a rising edge is one attack.
- hero_dir  in  2  attack direction: 00 up, 01 down, 10 left, 11 right.
- playing  out  1  high in PLAY.
- game_over  out  1  high in OVER.
- lives  out  $clog2(LIVES+1)  remaining lives.
- score  out  SCORE_W  kills this game, saturating.
- mon_valid  out  MONSTERS  slot occupied.
- mon_dir  out  2*MONSTERS  lane of slot i, bits [2i+1:2i].
- mon_step  out  STEP_W*MONSTERS  step of slot i; STEP_W = $clog2(STEPS).
- kill_pulse  out  MONSTERS  one-cycle pulse per killed slot.

## Operation
- Reset values: state IDLE; all outputs 0 except lives=0; LFSR=LFSR_SEED; edge-detect registers 0, so an input already high when reset releases counts as a rising edge.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle in every state.
- IDLE: all slots clear. A start edge loads lives=LIVES, score=0 and moves to PLAY.
- PLAY, on each move edge:
  - Every valid monster with step < STEPS-1 advances by 1.
  - Every valid monster at STEPS-1 that is not killed this cycle reaches the hero. Its slot clears and lives drops by 1 per arrival, saturating at 0.
  - If lfsr[1:0] != 0, spawn into the lowest-index slot that was free before this cycle: dir = lfsr[3:2], step 0. A newly spawned monster does not advance on the same edge. If no slot is free, there is no spawn.
- Attack: an attack_req edge in PLAY latches hero_dir and loads the window counter.
  - The window stays active for exactly ATTACK_WINDOW cycles.
  - A new edge while the window is active relatches the direction and restarts the window.
- Kill: while the window is active, every valid monster at STEPS-1 whose dir equals the latched direction is killed. Its slot clears, its kill_pulse bit pulses, and score increases by the number of kills that cycle, saturating at all-ones. This also kills monsters that arrive at STEPS-1 later in the same window.
- Simultaneous kill and move edge on one monster: the kill wins, and no life is lost.
- When lives reaches 0, go to OVER. All slots clear and the attack window cancels. Score holds; lives reads 0.
- OVER: a start edge begins a new game, as from IDLE. start edges during PLAY are ignored.
- Asserting rst_n low mid-game returns immediately to the reset values.

## Timing
- All outputs are registered.
- Edge detection compares the input with its registered previous value. The edge is seen in cycle n.
- Move and spawn: the edge in cycle n updates mon_* and lives, visible in cycle n+1.
- Attack: the edge in cycle n makes the window active in n+1. A kill is evaluated in n+1; valid low, kill_pulse high and the score increment are visible in n+2.
- kill_pulse stays high for exactly one cycle per kill.
- OVER: game_over rises in the cycle after lives is written to 0.

## Structure
- game_pkg holds:
  - the DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT encodings;
  - the state enum IDLE/PLAY/OVER;
  - the per-direction, per-step X/Y coordinate tables used by the renderer;
  - the LFSR tap constant.
- Sub-module lfsr16 (clk_game, rst_n, seed parameter, 16-bit state output).
- Per-slot logic is a generate loop inside this block; there is no per-slot module.

## Test plan
- Reset then start edge -> playing=1, lives=3, score=0, mon_valid=0 in the cycle after the edge is seen.
- LFSR forced to give lfsr[3:0]=4'b0101, then 3 move edges -> slot 0 valid, dir=01, step 0/1/2. A 4th edge -> slot 0 clears and lives=2.
- Monster of dir 10 at step 2 with attack edge and hero_dir=10 -> kill_pulse[0] high one cycle at n+2, score=1, lives unchanged. A repeat with hero_dir=11 -> no kill.
- Kill and move edge on the same cycle for a monster at step 2 -> killed, score+1, lives unchanged.
- Three arrivals on one move edge with lives=2 -> lives=0, then game_over=1, all slots clear. A start edge -> new game with score=0.
- rst_n pulsed low mid-window with 5 valid slots -> all outputs return to reset values at once; no kill_pulse after release.
